// File: rtl/bundle_linear_mapper.sv
// Address sequencer that bundles stored hypervectors element by element: reads the
// matching element of every input HV, streams it to a bundling kernel, writes the result.
module bundle_linear_mapper #(
  parameter int HV_DATA_WIDTH          = 32,
  parameter int HV_ADDRESS_WIDTH       = 5,
  parameter int MAX_HYPERVECTOR_LENGTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        valid,
  input  logic [HV_ADDRESS_WIDTH-1:0] hva,
  input  logic [HV_ADDRESS_WIDTH-1:0] hvb,
  input  logic [HV_ADDRESS_WIDTH-1:0] hvc,
  input  logic [HV_ADDRESS_WIDTH-1:0] hv_offset,
  input  logic                        mode,
  output logic                        we_n,
  output logic [HV_ADDRESS_WIDTH-1:0] address,
  output logic [HV_DATA_WIDTH-1:0]    data_wr,
  input  logic [HV_DATA_WIDTH-1:0]    data_rd,
  output logic                        done,
  output logic                        k_valid,
  output logic                        k_first,
  output logic                        k_last,
  output logic [HV_DATA_WIDTH-1:0]    k_data_in,
  input  logic [HV_DATA_WIDTH-1:0]    k_data_out,
  input  logic                        k_ready,
  input  logic                        k_done
);

  localparam int AW = HV_ADDRESS_WIDTH;
  localparam int DW = HV_DATA_WIDTH;
  localparam int L  = MAX_HYPERVECTOR_LENGTH;
  localparam int EW = (L > 1) ? $clog2(L) : 1;
  localparam logic [AW-1:0] L_AW   = AW'(L);
  localparam logic [EW-1:0] E_LAST = EW'(L - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_FEED, S_WAIT_K, S_WRITE, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [EW-1:0]   e_q;
  logic [AW-1:0]   i_q, last_q;
  logic [AW-1:0]   hva_q, hvb_q, hvc_q, off_q;
  logic            mode_q;
  logic [DW-1:0]   result_q;
  logic [AW-1:0]   base_i, rd_addr, wr_addr;

  // Range mode walks input HVs at a fixed stride; pair mode alternates hva/hvb.
  always_comb begin
    base_i  = mode_q ? (hva_q + i_q * L_AW) : ((i_q == '0) ? hva_q : hvb_q);
    rd_addr = off_q + base_i + AW'(e_q);
    wr_addr = off_q + hvc_q + AW'(e_q);
  end

  // NOTE: every output and next-state signal gets a default first so no branch can infer a latch.
  always_comb begin
    state_d   = state_q;
    we_n      = 1'b1;
    done      = 1'b0;
    k_valid   = 1'b0;
    k_first   = 1'b0;
    k_last    = 1'b0;
    address   = '0;
    data_wr   = '0;
    k_data_in = '0;
    case (state_q)
      S_IDLE: if (valid) state_d = S_RD;
      S_RD: begin
        address = rd_addr;
        state_d = S_FEED;
      end
      S_FEED: begin
        // Address stays on the read location so the registered RAM keeps presenting the word.
        address = rd_addr;
        if (k_ready) begin
          k_valid   = 1'b1;
          k_data_in = data_rd;
          k_first   = (i_q == '0);
          k_last    = (i_q == last_q);
          state_d   = (i_q == last_q) ? S_WAIT_K : S_RD;
        end
      end
      S_WAIT_K: if (k_done) state_d = S_WRITE;
      S_WRITE: begin
        address = wr_addr;
        data_wr = result_q;
        we_n    = 1'b0;
        state_d = (e_q == E_LAST) ? S_DONE : S_RD;
      end
      S_DONE: begin
        done = 1'b1;
        if (!valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      e_q      <= '0;
      i_q      <= '0;
      last_q   <= '0;
      hva_q    <= '0;
      hvb_q    <= '0;
      hvc_q    <= '0;
      off_q    <= '0;
      mode_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: if (valid) begin
          hva_q  <= hva;
          hvb_q  <= hvb;
          hvc_q  <= hvc;
          off_q  <= hv_offset;
          mode_q <= mode;
          last_q <= mode ? ((hvb - hva) / L_AW) : AW'(1);
          e_q    <= '0;
          i_q    <= '0;
        end
        S_FEED:   if (k_ready && (i_q != last_q)) i_q <= i_q + AW'(1);
        S_WAIT_K: if (k_done) result_q <= k_data_out;
        S_WRITE: begin
          i_q <= '0;
          if (e_q != E_LAST) e_q <= e_q + EW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bundle_linear_mapper.sv
// Self-checking bench: registered RAM model, float add/clip kernel model, and
// scoreboards for kernel beats and RAM writes, driven from a table of vectors.
module tb_bundle_linear_mapper;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid, mode;
  logic [4:0]  hva, hvb, hvc, hv_offset;
  logic        we_n, done, k_valid, k_first, k_last;
  logic [4:0]  address;
  logic [31:0] data_wr, data_rd, k_data_in, k_data_out;
  logic        k_ready, k_done;

  always #5 clk = ~clk;

  bundle_linear_mapper dut (
    .clk(clk), .reset(reset), .valid(valid), .hva(hva), .hvb(hvb), .hvc(hvc),
    .hv_offset(hv_offset), .mode(mode), .we_n(we_n), .address(address),
    .data_wr(data_wr), .data_rd(data_rd), .done(done), .k_valid(k_valid),
    .k_first(k_first), .k_last(k_last), .k_data_in(k_data_in),
    .k_data_out(k_data_out), .k_ready(k_ready), .k_done(k_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Registered single-port RAM; the bench preloads through its own write port.
  logic [31:0] mem [32];
  logic        tb_we = 1'b0;
  logic [4:0]  tb_addr = '0;
  logic [31:0] tb_wdata = '0;
  always @(posedge clk) begin
    if (tb_we) mem[tb_addr] <= tb_wdata;
    else if (!we_n) mem[address] <= data_wr;
    data_rd <= mem[address];
  end

  function automatic real f2r(input logic [31:0] b);
    real r;
    int  ex;
    if (b[30:0] == 31'd0) return 0.0;
    r  = 1.0 + real'(b[22:0]) / 8388608.0;
    ex = int'(b[30:23]) - 127;
    while (ex > 0) begin r = r * 2.0; ex--; end
    while (ex < 0) begin r = r / 2.0; ex++; end
    return b[31] ? -r : r;
  endfunction

  function automatic logic [31:0] r2f(input real r);
    real        a;
    int         ex;
    logic [7:0] eb;
    logic [22:0] m;
    if (r == 0.0) return 32'h0;
    a  = (r < 0.0) ? -r : r;
    ex = 127;
    while (a >= 2.0) begin a = a / 2.0; ex++; end
    while (a < 1.0) begin a = a * 2.0; ex--; end
    eb = 8'(ex);
    m  = 23'(int'((a - 1.0) * 8388608.0));
    return {(r < 0.0), eb, m};
  endfunction

  function automatic real kern_sum(input logic first, input real acc, input logic [31:0] w);
    return (first ? 0.0 : acc) + f2r(w);
  endfunction

  function automatic real clip(input real s);
    if (s > 1.0) return 1.0;
    if (s < -1.0) return -1.0;
    return s;
  endfunction

  // Bundling kernel: float add, clip to +/-1.0, k_done pulses two edges after the last word.
  real  acc;
  logic pend;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      k_done     <= 1'b0;
      pend       <= 1'b0;
      k_data_out <= '0;
      acc        <= 0.0;
    end else begin
      k_done <= pend;
      pend   <= 1'b0;
      if (k_valid && k_ready) begin
        acc <= kern_sum(k_first, acc, k_data_in);
        if (k_last) begin
          k_data_out <= r2f(clip(kern_sum(k_first, acc, k_data_in)));
          pend       <= 1'b1;
        end
      end
    end
  end

  initial begin
    k_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 k_ready = ($urandom_range(0, 3) != 0);
    end
  end

  typedef struct packed {
    logic [1:0]  f_l;
    logic [31:0] d;
  } beat_t;
  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;
  beat_t beat_q[$];
  wr_t   wr_q[$];
  bit    beat_en = 1'b0;

  initial begin
    beat_t b;
    wr_t   w;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        if (k_valid) begin
          check("k_valid_needs_k_ready", 128'(k_ready), 128'(1));
          if (beat_en) begin
            if (beat_q.size() == 0) check("beat_unexpected", 128'(1), 128'(0));
            else begin
              b = beat_q.pop_front();
              check("beat_first_last_data", 128'({k_first, k_last, k_data_in}), 128'(b));
            end
          end
        end
        if (!we_n) begin
          if (wr_q.size() == 0) check("write_unexpected", 128'({address, data_wr}), 128'(0));
          else begin
            w = wr_q.pop_front();
            check("write_addr_data", 128'({address, data_wr}), 128'(w));
          end
        end
      end
    end
  end

  typedef struct packed {
    logic        mode;
    logic [4:0]  hva, hvb, hvc, off;
    logic [1:0]  n;
    logic [2:0][31:0] w;
    logic [31:0] exp;
    logic        drop_early;
  } vec_t;

  function automatic vec_t mk(input logic m, input logic [4:0] a, input logic [4:0] b,
                              input logic [4:0] c, input logic [4:0] o, input logic [1:0] n,
                              input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input logic [31:0] exp, input logic drop);
    vec_t v;
    v.mode = m; v.hva = a; v.hvb = b; v.hvc = c; v.off = o; v.n = n;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.exp = exp; v.drop_early = drop;
    return v;
  endfunction

  function automatic logic [4:0] in_addr(input vec_t v, input int i, input int e);
    logic [4:0] base;
    base = v.mode ? (v.hva + 5'(i * 4)) : ((i == 0) ? v.hva : v.hvb);
    return v.off + base + 5'(e);
  endfunction

  task automatic poke(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    tb_we = 1'b1; tb_addr = a; tb_wdata = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int c = 0; c < 400 && done !== 1'b1; c++) @(negedge clk);
    check(name, 128'(done), 128'(1));
  endtask

  function automatic logic [127:0] outs();
    return 128'({we_n, done, k_valid, k_first, k_last, address, data_wr, k_data_in});
  endfunction
  localparam logic [127:0] RESET_OUTS = 128'({1'b1, 73'd0});

  // Elements 0 and 2 carry the vector's words, elements 1 and 3 are all zero.
  task automatic run_vec(input vec_t v, input string tag);
    logic [31:0] wd;
    for (int a = 0; a < 32; a++) poke(5'(a), 32'h0);
    for (int e = 0; e < 4; e += 2)
      for (int i = 0; i < int'(v.n); i++) poke(in_addr(v, i, e), v.w[i]);
    for (int e = 0; e < 4; e++) begin
      for (int i = 0; i < int'(v.n); i++) begin
        wd = (e % 2 == 0) ? v.w[i] : 32'h0;
        beat_q.push_back({(i == 0), (i == int'(v.n) - 1), wd});
      end
      wr_q.push_back({v.off + v.hvc + 5'(e), ((e % 2 == 0) ? v.exp : 32'h0)});
    end
    beat_en = 1'b1;
    @(negedge clk);
    mode = v.mode; hva = v.hva; hvb = v.hvb; hvc = v.hvc; hv_offset = v.off; valid = 1'b1;
    @(negedge clk);
    hva = 5'($urandom); hvb = 5'($urandom); hvc = 5'($urandom);
    hv_offset = 5'($urandom); mode = ~v.mode;
    if (v.drop_early) valid = 1'b0;
    wait_done({tag, "_done"});
    if (!v.drop_early) begin
      repeat (3) @(negedge clk);
      check({tag, "_done_held"}, 128'(done), 128'(1));
      valid = 1'b0;
    end
    @(negedge clk);
    check({tag, "_done_clear"}, 128'(done), 128'(0));
    check({tag, "_beats_left"}, 128'(beat_q.size()), 128'(0));
    check({tag, "_writes_left"}, 128'(wr_q.size()), 128'(0));
    for (int e = 0; e < 4; e++)
      check({tag, "_ram_out"}, 128'(mem[v.off + v.hvc + 5'(e)]),
            128'((e % 2 == 0) ? v.exp : 32'h0));
    check({tag, "_ram_in_kept"}, 128'(mem[in_addr(v, int'(v.n) - 1, 2)]), 128'(v.w[int'(v.n) - 1]));
    beat_q.delete();
    wr_q.delete();
    beat_en = 1'b0;
  endtask

  vec_t vt[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = mk(1'b1, 5'd0,  5'd4,  5'd8,  5'd0, 2'd2, 32'h3F800000, 32'h3F800000, 32'h0,        32'h3F800000, 1'b0);
    vt[1] = mk(1'b1, 5'd0,  5'd4,  5'd8,  5'd0, 2'd2, 32'h3F800000, 32'hBF800000, 32'h0,        32'h00000000, 1'b1);
    vt[2] = mk(1'b1, 5'd0,  5'd8,  5'd12, 5'd0, 2'd3, 32'h3F000000, 32'h3E800000, 32'hBF800000, 32'hBE800000, 1'b0);
    vt[3] = mk(1'b1, 5'd0,  5'd0,  5'd8,  5'd1, 2'd1, 32'h3F000000, 32'h0,        32'h0,        32'h3F000000, 1'b0);
    vt[4] = mk(1'b0, 5'd0,  5'd12, 5'd4,  5'd0, 2'd2, 32'h3F000000, 32'hBF800000, 32'h0,        32'hBF000000, 1'b0);
    vt[5] = mk(1'b1, 5'd28, 5'd0,  5'd16, 5'd0, 2'd2, 32'h3F000000, 32'h3F000000, 32'h0,        32'h3F800000, 1'b0);

    reset = 1'b1; valid = 1'b0; mode = 1'b0;
    hva = '0; hvb = '0; hvc = '0; hv_offset = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", outs(), RESET_OUTS);
    reset = 1'b0;
    @(negedge clk);
    check("idle_outputs", outs(), RESET_OUTS);

    for (int t = 0; t < 6; t++) run_vec(vt[t], $sformatf("vec%0d", t));

    // Reset while feeding the kernel must abort before any write to the output HV.
    for (int a = 0; a < 32; a++) poke(5'(a), (a >= 8 && a < 12) ? 32'hDEADBEEF : 32'h0);
    poke(5'd0, 32'h3F800000);
    poke(5'd4, 32'h3F800000);
    @(negedge clk);
    mode = 1'b1; hva = 5'd0; hvb = 5'd4; hvc = 5'd8; hv_offset = 5'd0; valid = 1'b1;
    for (int c = 0; c < 50 && k_valid !== 1'b1; c++) @(negedge clk);
    check("abort_reached_feed", 128'(k_valid), 128'(1));
    reset = 1'b1;
    #1;
    check("abort_outputs_reset", outs(), RESET_OUTS);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    valid = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_no_done", 128'(done), 128'(0));
    for (int a = 8; a < 12; a++)
      check("abort_hvc_unchanged", 128'(mem[a]), 128'(32'hDEADBEEF));

    run_vec(vt[2], "recover");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
